// File: rtl/csa_pipe_adder_pkg.sv
// Shared defaults and geometry helpers for the pipelined carry-select adder.
// Holds the default width/block/stage sizing and the derived-size functions.
package csa_pipe_adder_pkg;

  localparam int DEF_W   = 64;
  localparam int DEF_BLK = 4;
  localparam int DEF_BPS = 4;

  function automatic int seg_bits(input int blk, input int bps);
    return blk * bps;
  endfunction

  function automatic int num_stages(input int w, input int blk, input int bps);
    return w / seg_bits(blk, bps);
  endfunction

  function automatic bit geometry_ok(input int w, input int blk, input int bps);
    return (blk > 0) && (bps > 0) && (w >= seg_bits(blk, bps)) &&
           (w % seg_bits(blk, bps) == 0);
  endfunction

endpackage

// File: rtl/csa_pipe_adder_blk.sv
// One carry-select block: two ripple adders assuming carry-in 0 and 1,
// with the real block carry choosing between the precomputed results.
module csa_blk #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           c_in,
  output logic [BLK-1:0] sum,
  output logic           c_out
);

  logic [BLK:0]   c0, c1;
  logic [BLK-1:0] s0, s1;

  always_comb begin
    c0    = '0;
    c1    = '0;
    s0    = '0;
    s1    = '0;
    c1[0] = 1'b1;
    for (int i = 0; i < BLK; i++) begin
      s0[i]   = a[i] ^ b[i] ^ c0[i];
      c0[i+1] = (a[i] & b[i]) | (c0[i] & (a[i] ^ b[i]));
      s1[i]   = a[i] ^ b[i] ^ c1[i];
      c1[i+1] = (a[i] & b[i]) | (c1[i] & (a[i] ^ b[i]));
    end
  end

  assign sum   = c_in ? s1 : s0;
  assign c_out = c_in ? c1[BLK] : c0[BLK];

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor, one SEG-bit slice per stage, with
// operand skew and sum de-skew registers and a stall-all valid/ready handshake.
module csa_pipe_adder
  import csa_pipe_adder_pkg::*;
#(
  parameter int W   = DEF_W,
  parameter int BLK = DEF_BLK,
  parameter int BPS = DEF_BPS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         ovf
);

  localparam int SEG  = seg_bits(BLK, BPS);
  localparam int NSTG = num_stages(W, BLK, BPS);

  if (!geometry_ok(W, BLK, BPS)) begin : g_bad_cfg
    $error("csa_pipe_adder: W must be a nonzero multiple of BLK*BPS");
  end

  logic en;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int REM  = W - k * SEG;
    localparam int DONE = (k + 1) * SEG;

    logic [REM-1:0]  a_in, b_in;
    logic            v_in;
    logic [BPS:0]    bc;
    logic [SEG-1:0]  seg_sum;
    logic [DONE-1:0] sum_d, sum_q;
    logic            v_q, c_q;

    // Stage 0 takes the ports (b pre-inverted for subtract); later stages
    // take the previous stage's skewed operands, carry and finished sum bits.
    if (k == 0) begin : g_src
      assign a_in  = a;
      assign b_in  = sub ? ~b : b;
      assign bc[0] = sub | c_in;
      assign v_in  = in_valid;
      assign sum_d = seg_sum;
    end else begin : g_src
      assign a_in  = g_stg[k-1].g_skew.a_q;
      assign b_in  = g_stg[k-1].g_skew.b_q;
      assign bc[0] = g_stg[k-1].c_q;
      assign v_in  = g_stg[k-1].v_q;
      assign sum_d = {seg_sum, g_stg[k-1].sum_q};
    end

    for (genvar j = 0; j < BPS; j++) begin : g_blk
      csa_blk #(.BLK(BLK)) u_blk (
        .a     (a_in[j*BLK +: BLK]),
        .b     (b_in[j*BLK +: BLK]),
        .c_in  (bc[j]),
        .sum   (seg_sum[j*BLK +: BLK]),
        .c_out (bc[j+1])
      );
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (en) begin
        v_q   <= v_in;
        c_q   <= bc[BPS];
        sum_q <= sum_d;
      end
    end

    if (k < NSTG - 1) begin : g_skew
      logic [REM-SEG-1:0] a_q, b_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_in[REM-1:SEG];
          b_q <= b_in[REM-1:SEG];
        end
      end
    end

    if (k == NSTG - 1) begin : g_last
      logic msb_cin;
      logic ovf_q;

      // The carry into the MSB is recovered from the MSB's own sum bit.
      assign msb_cin = a_in[SEG-1] ^ b_in[SEG-1] ^ seg_sum[SEG-1];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= bc[BPS] ^ msb_cin;
        end
      end
    end
  end

  assign out_valid = g_stg[NSTG-1].v_q;
  assign sum       = g_stg[NSTG-1].sum_q;
  assign c_out     = g_stg[NSTG-1].c_q;
  assign ovf       = g_stg[NSTG-1].g_last.ovf_q;
  assign en        = !out_valid | out_ready;
  assign in_ready  = en;

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Self-checking bench for csa_pipe_adder: directed literal cases plus random
// streams scored against a plain-arithmetic model, on 64-bit and 32-bit builds.
module tb_csa_pipe_adder;

  localparam int NSTG  = 4;
  localparam int NSTG2 = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, out_ready2;
  logic [63:0] a, b;
  logic        c_in, sub;
  logic        in_ready, out_valid, c_out, ovf;
  logic [63:0] sum;
  logic        in_ready2, out_valid2, c_out2, ovf2;
  logic [31:0] sum2;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [65:0] exp_q[$];
  logic [65:0] exp2_q[$];
  logic        stall_prev = 1'b0;
  logic [65:0] held;

  always #5 clk = ~clk;

  csa_pipe_adder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .c_out(c_out), .ovf(ovf)
  );

  csa_pipe_adder #(.W(32), .BLK(2), .BPS(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a[31:0]), .b(b[31:0]), .c_in(c_in), .sub(sub), .out_valid(out_valid2),
    .out_ready(out_ready2), .sum(sum2), .c_out(c_out2), .ovf(ovf2)
  );

  // Result = {ovf, c_out, sum} for a w-bit add/sub, from integer arithmetic
  function automatic logic [65:0] model(input logic [63:0] x, input logic [63:0] y,
                                        input logic ci, input logic sb, input int w);
    logic [64:0] mask, bx, t;
    logic        sgn_a, sgn_b, sgn_s, v;
    mask  = (65'd1 << w) - 65'd1;
    bx    = (sb ? {1'b0, ~y} : {1'b0, y}) & mask;
    t     = ({1'b0, x} & mask) + bx + (sb ? 65'd1 : {64'd0, ci});
    sgn_a = x[w-1];
    sgn_b = bx[w-1];
    sgn_s = t[w-1];
    v     = (sgn_a == sgn_b) && (sgn_s != sgn_a);
    return {v, t[w], 64'(t & mask)};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle scoreboard: handshake rule, stall stability, in-order results
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp2_q.delete();
      stall_prev = 1'b0;
    end else begin
      checkOutput("in_ready_rule", 128'(in_ready), 128'(!out_valid | out_ready));
      if (stall_prev) begin
        checkOutput("stall_valid", 128'(out_valid), 128'(1));
        checkOutput("stall_stable", 128'({ovf, c_out, sum}), 128'(held));
      end
      if (out_valid) begin
        if (exp_q.size() == 0)
          checkOutput("spurious_result", 128'(out_valid), 128'(0));
        else begin
          checkOutput("result64", 128'({ovf, c_out, sum}), 128'(exp_q[0]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, c_in, sub, 64));
      stall_prev = out_valid && !out_ready;
      held       = {ovf, c_out, sum};

      if (out_valid2) begin
        if (exp2_q.size() == 0)
          checkOutput("spurious_result32", 128'(out_valid2), 128'(0));
        else begin
          checkOutput("result32", 128'({ovf2, c_out2, sum2}), 128'(exp2_q[0][33:0]));
          void'(exp2_q.pop_front());
        end
      end
      if (in_valid && in_ready2) begin
        logic [65:0] r;
        r = model(a, b, c_in, sub, 32);
        exp2_q.push_back({32'd0, r[65], r[64], r[31:0]});
      end
    end
  end

  function automatic logic [63:0] randOperand();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Single directed op into an empty pipe; checks latency and literal result
  task automatic applyStimulus(input string name, input logic [63:0] xa,
                               input logic [63:0] xb, input logic ci, input logic sb,
                               input logic [63:0] esum, input logic ec, input logic eo);
    int n;
    a = xa; b = xb; c_in = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({name, "_latency"}, 128'(n), 128'(NSTG - 1));
    checkOutput({name, "_sum"}, 128'(sum), 128'(esum));
    checkOutput({name, "_cout"}, 128'(c_out), 128'(ec));
    checkOutput({name, "_ovf"}, 128'(ovf), 128'(eo));
    @(posedge clk); #1;
  endtask

  // readyMode 0: always ready, 1: pattern 1,0,0 repeating, 2: random
  task automatic runStream(input string name, input int nops, input int readyMode,
                           input int validPct);
    int   sent = 0;
    int   cyc = 0;
    int   budget = nops * 12 + 100;
    logic pending = 1'b0;
    logic [63:0] pa = '0, pb = '0;
    logic pc = 1'b0, ps = 1'b0;
    while ((sent < nops || exp_q.size() != 0) && cyc < budget) begin
      case (readyMode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = ($urandom_range(0, 99) < 60);
      endcase
      if (!pending && sent < nops && $urandom_range(0, 99) < validPct) begin
        pa = randOperand(); pb = randOperand();
        pc = 1'($urandom); ps = 1'($urandom);
        pending = 1'b1;
      end
      in_valid = pending; a = pa; b = pb; c_in = pc; sub = ps;
      #1;
      if (pending && in_ready) begin
        pending = 1'b0;
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput({name, "_sent"}, 128'(sent), 128'(nops));
    checkOutput({name, "_drained"}, 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; out_ready2 = 1'b1;
    a = 64'h1234; b = 64'h5678; c_in = 1'b0; sub = 1'b0;

    // Reset held two edges with operands offered
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    checkOutput("reset_out_valid", 128'(out_valid), 128'(0));
    checkOutput("reset_sum", 128'(sum), 128'(0));
    checkOutput("reset_in_ready", 128'(in_ready), 128'(1));
    checkOutput("reset_cout_ovf", 128'({c_out, ovf}), 128'(0));
    @(posedge clk); #1;

    applyStimulus("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0,
                  64'd0, 1'b1, 1'b0);
    applyStimulus("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
                  64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    applyStimulus("sub_neg", 64'd5, 64'd7, 1'b1, 1'b1,
                  64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    applyStimulus("add_plain", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b1, 1'b0,
                  64'h0000_0001_0000_0001, 1'b0, 1'b0);

    runStream("backpressure", 10, 1, 100);

    // Three ops in flight, then reset: none may emerge
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = randOperand(); b = randOperand(); c_in = 1'b1; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("flush_no_result", 128'(out_valid), 128'(0));
    applyStimulus("after_flush", 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111,
                  1'b0, 1'b0, 64'h1234_5678_9ABC_DF00, 1'b0, 1'b0);

    runStream("full_rate", 200, 0, 100);
    runStream("random", 10000, 2, 70);

    repeat (NSTG2 + 2) @(posedge clk);
    #1;
    checkOutput("w32_drained", 128'(exp2_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
